// File: rtl/store_buffer.sv
// Store buffer: holds speculative stores in program order, drains retired ones to the D-cache.
// Define STB_FWD_EN to build the store-to-load forwarding mux; otherwise loads only see a stall.
module store_buffer #(
    parameter int NUM_ENTRIES    = 4,
    parameter int XLEN           = 32,
    parameter int ROB_TICKET_LEN = 4,
    parameter int ADDR_LEN       = XLEN,
    parameter int TICKET_LEN     = ROB_TICKET_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  push_valid_in,
    input  logic [ADDR_LEN-1:0]   push_addr_in,
    input  logic [XLEN-1:0]       push_data_in,
    input  logic                  push_byte_in,
    input  logic [TICKET_LEN-1:0] push_ticket_in,
    output logic                  full_out,
    output logic                  empty_out,
    input  logic                  commit_in,
    input  logic [TICKET_LEN-1:0] commit_ticket_in,
    input  logic                  flush_in,
    output logic                  drain_valid_out,
    output logic [ADDR_LEN-1:0]   drain_addr_out,
    output logic [XLEN-1:0]       drain_data_out,
    output logic                  drain_byte_out,
    input  logic                  drain_ready_in,
    input  logic [ADDR_LEN-1:0]   ld_addr_in,
    input  logic                  ld_byte_in,
    output logic                  ld_hit_out,
    output logic [XLEN-1:0]       ld_data_out,
    output logic                  ld_stall_out
);
    localparam int PW = $clog2(NUM_ENTRIES);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic                  valid;
        logic                  committed;
        logic [ADDR_LEN-1:0]   addr;
        logic [XLEN-1:0]       data;
        logic                  is_byte;
        logic [TICKET_LEN-1:0] ticket;
    } entry_t;

    entry_t [NUM_ENTRIES-1:0] ent;
    logic [PW-1:0] head, cmt_ptr, tail;
    logic [CW-1:0] count, ncom;

    logic do_push, do_commit, do_pop, do_flush;
    logic [PW-1:0] cmt_nx;
    logic [CW-1:0] ncom_nx;

    assign full_out  = (count == CW'(NUM_ENTRIES));
    assign empty_out = (count == '0);

    // ncom counts committed entries; commit only has a target while some entry is still speculative
    assign do_commit = enable & commit_in & (ncom != count);
    assign do_flush  = enable & flush_in;
    assign do_push   = enable & push_valid_in & ~full_out & ~flush_in;
    assign drain_valid_out = enable & ent[head].valid & ent[head].committed;
    assign do_pop    = drain_valid_out & drain_ready_in;

    assign drain_addr_out = ent[head].addr;
    assign drain_data_out = ent[head].data;
    assign drain_byte_out = ent[head].is_byte;

    assign cmt_nx  = cmt_ptr + PW'(do_commit);
    assign ncom_nx = ncom + CW'(do_commit) - CW'(do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent     <= '0;
            head    <= '0;
            cmt_ptr <= '0;
            tail    <= '0;
            count   <= '0;
            ncom    <= '0;
        end else begin
            // the entry committed this cycle survives a simultaneous flush
            for (int i = 0; i < NUM_ENTRIES; i++)
                if (do_flush && !ent[i].committed && !(do_commit && PW'(i) == cmt_ptr))
                    ent[i].valid <= 1'b0;
            if (do_commit)
                ent[cmt_ptr].committed <= 1'b1;
            if (do_pop) begin
                ent[head].valid     <= 1'b0;
                ent[head].committed <= 1'b0;
            end
            if (do_push) begin
                ent[tail].valid     <= 1'b1;
                ent[tail].committed <= 1'b0;
                ent[tail].addr      <= push_addr_in;
                ent[tail].data      <= push_data_in;
                ent[tail].is_byte   <= push_byte_in;
                ent[tail].ticket    <= push_ticket_in;
            end
            head    <= head + PW'(do_pop);
            cmt_ptr <= cmt_nx;
            tail    <= do_flush ? cmt_nx : tail + PW'(do_push);
            ncom    <= ncom_nx;
            count   <= do_flush ? ncom_nx : count + CW'(do_push) - CW'(do_pop);
        end
    end

    logic [PW-1:0] idx;

`ifdef STB_FWD_EN
    logic            fwd_hit, fwd_stall;
    logic [XLEN-1:0] fwd_data;

    // walk oldest to youngest so the youngest overlapping store has the last word
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            idx = head + PW'(k);
            if (ent[idx].valid && ent[idx].addr[ADDR_LEN-1:2] == ld_addr_in[ADDR_LEN-1:2]) begin
                if (!ent[idx].is_byte) begin
                    fwd_hit   = 1'b1;
                    fwd_stall = 1'b0;
                    fwd_data  = ld_byte_in ? XLEN'(ent[idx].data[{ld_addr_in[1:0], 3'b000} +: 8])
                                           : ent[idx].data;
                end else if (!ld_byte_in) begin
                    fwd_hit   = 1'b0;
                    fwd_stall = 1'b1;
                    fwd_data  = '0;
                end else if (ent[idx].addr[1:0] == ld_addr_in[1:0]) begin
                    fwd_hit   = 1'b1;
                    fwd_stall = 1'b0;
                    fwd_data  = XLEN'(ent[idx].data[7:0]);
                end
            end
        end
    end

    assign ld_hit_out   = fwd_hit;
    assign ld_stall_out = fwd_stall;
    assign ld_data_out  = fwd_data;
`else
    logic word_match;
    logic unused_ld;

    always_comb begin
        word_match = 1'b0;
        idx        = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            idx = head + PW'(k);
            if (ent[idx].valid && ent[idx].addr[ADDR_LEN-1:2] == ld_addr_in[ADDR_LEN-1:2])
                word_match = 1'b1;
        end
    end

    assign unused_ld    = ^{ld_byte_in, ld_addr_in[1:0]};
    assign ld_hit_out   = 1'b0;
    assign ld_stall_out = word_match;
    assign ld_data_out  = '0;
`endif

    a_commit_ticket: assert property (@(posedge clk) disable iff (!reset)
        do_commit |-> commit_ticket_in == ent[cmt_ptr].ticket);

endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer against a queue-based program-order model.
module tb_store_buffer;
    localparam int N  = 4;
    localparam int XL = 32;
    localparam int AL = 32;
    localparam int TL = 4;

    logic          clk = 1'b0, reset = 1'b0, enable = 1'b0;
    logic          push_valid_in = 1'b0, push_byte_in = 1'b0;
    logic [AL-1:0] push_addr_in = '0;
    logic [XL-1:0] push_data_in = '0;
    logic [TL-1:0] push_ticket_in = '0, commit_ticket_in = '0;
    logic          commit_in = 1'b0, flush_in = 1'b0, drain_ready_in = 1'b0, ld_byte_in = 1'b0;
    logic [AL-1:0] ld_addr_in = '0;
    logic          full_out, empty_out, drain_valid_out, drain_byte_out, ld_hit_out, ld_stall_out;
    logic [AL-1:0] drain_addr_out;
    logic [XL-1:0] drain_data_out, ld_data_out;

    always #5 clk = ~clk;

    store_buffer #(.NUM_ENTRIES(N), .XLEN(XL), .ROB_TICKET_LEN(TL)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .push_valid_in(push_valid_in), .push_addr_in(push_addr_in), .push_data_in(push_data_in),
        .push_byte_in(push_byte_in), .push_ticket_in(push_ticket_in),
        .full_out(full_out), .empty_out(empty_out),
        .commit_in(commit_in), .commit_ticket_in(commit_ticket_in), .flush_in(flush_in),
        .drain_valid_out(drain_valid_out), .drain_addr_out(drain_addr_out),
        .drain_data_out(drain_data_out), .drain_byte_out(drain_byte_out),
        .drain_ready_in(drain_ready_in),
        .ld_addr_in(ld_addr_in), .ld_byte_in(ld_byte_in),
        .ld_hit_out(ld_hit_out), .ld_data_out(ld_data_out), .ld_stall_out(ld_stall_out)
    );

    typedef struct {
        logic [AL-1:0] addr;
        logic [XL-1:0] data;
        logic          b;
        logic [TL-1:0] t;
        logic          c;
    } ent_t;

    ent_t q[$];        // q[0] is the oldest store
    int   ncom   = 0;  // committed stores form q[0 .. ncom-1]
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // first overlapping store, scanning youngest to oldest, decides the load's fate
    function automatic void model_fwd(output logic h, output logic s, output logic [XL-1:0] d);
        h = 1'b0; s = 1'b0; d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr[AL-1:2] == ld_addr_in[AL-1:2]) begin
`ifdef STB_FWD_EN
                if (!q[i].b) begin
                    h = 1'b1;
                    d = ld_byte_in ? ((q[i].data >> (8 * ld_addr_in[1:0])) & 32'hFF) : q[i].data;
                    return;
                end else if (!ld_byte_in) begin
                    s = 1'b1;
                    return;
                end else if (q[i].addr[1:0] == ld_addr_in[1:0]) begin
                    h = 1'b1;
                    d = {24'b0, q[i].data[7:0]};
                    return;
                end
`else
                s = 1'b1;
                return;
`endif
            end
        end
    endfunction

    task automatic model_update();
        bit full, pop, cm;
        ent_t e;
        if (!reset) begin q.delete(); ncom = 0; return; end
        if (!enable) return;
        full = (q.size() == N);
        pop  = (q.size() > 0) && q[0].c && drain_ready_in;
        cm   = commit_in && (ncom < q.size());
        if (cm) begin q[ncom].c = 1'b1; ncom++; end
        if (pop) begin void'(q.pop_front()); ncom--; end
        if (flush_in) begin
            while (q.size() > ncom) void'(q.pop_back());
        end else if (push_valid_in && !full) begin
            e.addr = push_addr_in; e.data = push_data_in; e.b = push_byte_in;
            e.t = push_ticket_in; e.c = 1'b0;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        logic eh, es;
        logic [XL-1:0] ed;
        bit dv;
        dv = enable && q.size() > 0 && q[0].c;
        chk("empty", empty_out, q.size() == 0);
        chk("full", full_out, q.size() == N);
        chk("drain_valid", drain_valid_out, dv);
        if (dv) begin
            chk("drain_addr", drain_addr_out, q[0].addr);
            chk("drain_data", drain_data_out, q[0].data);
            chk("drain_byte", drain_byte_out, q[0].b);
        end
        model_fwd(eh, es, ed);
        chk("ld_hit", ld_hit_out, eh);
        chk("ld_stall", ld_stall_out, es);
        if (eh) chk("ld_data", ld_data_out, ed);
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        enable = 1'b1; push_valid_in = 1'b0; commit_in = 1'b0; flush_in = 1'b0;
        drain_ready_in = 1'b0; ld_addr_in = 32'hF000; ld_byte_in = 1'b0;
    endtask

    task automatic push(input logic [AL-1:0] a, input logic [XL-1:0] d, input logic b, input logic [TL-1:0] t);
        push_valid_in = 1'b1; push_addr_in = a; push_data_in = d; push_byte_in = b; push_ticket_in = t;
    endtask

    task automatic commit(input logic [TL-1:0] t);
        commit_in = 1'b1; commit_ticket_in = t;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        step(); step();
        chk("rst_empty", empty_out, 1'b1);
        chk("rst_full", full_out, 1'b0);
        chk("rst_dv", drain_valid_out, 1'b0);
        chk("rst_hit", ld_hit_out, 1'b0);
        chk("rst_stall", ld_stall_out, 1'b0);
        reset = 1'b1;
        step();

        // single store: push, commit, drain
        idle(); push(32'h100, 32'hDEADBEEF, 1'b0, 4'd3); step();
        idle(); commit(4'd3); step();
        idle(); drain_ready_in = 1'b1; #1;
        chk("t1_dv", drain_valid_out, 1'b1);
        chk("t1_addr", drain_addr_out, 32'h100);
        chk("t1_data", drain_data_out, 32'hDEADBEEF);
        step();
        idle(); #1 chk("t1_empty", empty_out, 1'b1);

        // fill, refused push, pop+push at full, pointer wrap
        for (int i = 0; i < 4; i++) begin
            idle(); push(32'h300 + 32'(4 * i), 32'(i + 1), 1'b0, 4'(i)); step();
        end
        idle(); #1 chk("t2_full", full_out, 1'b1);
        push(32'h400, 32'h55, 1'b0, 4'd4); step();
        idle(); commit(4'd0); step();
        idle(); drain_ready_in = 1'b1; push(32'h500, 32'h66, 1'b0, 4'd4); step();
        idle(); #1 chk("t2_notfull", full_out, 1'b0);
        push(32'h600, 32'h77, 1'b0, 4'd4); step();
        idle(); #1 chk("t2_refull", full_out, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            idle(); commit(4'(i)); step();
        end
        idle(); drain_ready_in = 1'b1; #1 chk("t2_d0", drain_addr_out, 32'h304); step();
        #1 chk("t2_d1", drain_addr_out, 32'h308); step();
        #1 chk("t2_d2", drain_addr_out, 32'h30C); step();
        #1 chk("t2_d3", drain_addr_out, 32'h600);
        chk("t2_d3data", drain_data_out, 32'h77); step();
        idle(); #1 chk("t2_empty", empty_out, 1'b1);

        // forwarding word then byte into the same word
        push(32'h200, 32'h11223344, 1'b0, 4'd5); step();
        idle(); push(32'h201, 32'hFFFFFFAA, 1'b1, 4'd6); step();
        idle(); ld_addr_in = 32'h201; ld_byte_in = 1'b1; #1;
`ifdef STB_FWD_EN
        chk("t3_b201_hit", ld_hit_out, 1'b1);
        chk("t3_b201_data", ld_data_out, 32'hAA);
        ld_addr_in = 32'h203; #1;
        chk("t3_b203_hit", ld_hit_out, 1'b1);
        chk("t3_b203_data", ld_data_out, 32'h11);
`else
        chk("t3_nf_hit", ld_hit_out, 1'b0);
        chk("t3_nf_stall", ld_stall_out, 1'b1);
`endif
        ld_addr_in = 32'h200; ld_byte_in = 1'b0; #1;
        chk("t3_w200_stall", ld_stall_out, 1'b1);
        chk("t3_w200_hit", ld_hit_out, 1'b0);
        commit(4'd5); step();
        commit(4'd6); drain_ready_in = 1'b1; step();
        commit_in = 1'b0; step();
        #1 chk("t3_drained_stall", ld_stall_out, 1'b0);
        chk("t3_drained_hit", ld_hit_out, 1'b0);

        // commit and flush together
        idle(); push(32'h700, 32'hA, 1'b0, 4'd7); step();
        idle(); push(32'h710, 32'hB, 1'b0, 4'd8); step();
        idle(); push(32'h720, 32'hC, 1'b0, 4'd9); step();
        idle(); commit(4'd7); flush_in = 1'b1; step();
        idle(); ld_addr_in = 32'h710; #1;
        chk("t4_dv", drain_valid_out, 1'b1);
        chk("t4_addr", drain_addr_out, 32'h700);
        chk("t4_miss_hit", ld_hit_out, 1'b0);
        chk("t4_miss_stall", ld_stall_out, 1'b0);
        drain_ready_in = 1'b1; step();
        idle(); #1 chk("t4_empty", empty_out, 1'b1);

        // backpressure stability, then async reset mid-drain
        push(32'h800, 32'hCAFEF00D, 1'b0, 4'd10); step();
        idle(); commit(4'd10); step();
        idle(); ld_addr_in = 32'h800;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_hold_dv", drain_valid_out, 1'b1);
            chk("t5_hold_addr", drain_addr_out, 32'h800);
            chk("t5_hold_data", drain_data_out, 32'hCAFEF00D);
            step();
        end
        reset = 1'b0; q.delete(); ncom = 0; #1;
        chk("t5_rst_dv", drain_valid_out, 1'b0);
        chk("t5_rst_empty", empty_out, 1'b1);
        chk("t5_rst_hit", ld_hit_out, 1'b0);
        chk("t5_rst_stall", ld_stall_out, 1'b0);
        step(); step();
        reset = 1'b1; step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            enable           = ($urandom_range(0, 9) != 0);
            push_valid_in    = ($urandom_range(0, 2) != 0);
            push_addr_in     = 32'h100 + 32'($urandom_range(0, 11));
            push_data_in     = $urandom;
            push_byte_in     = 1'($urandom_range(0, 1));
            push_ticket_in   = 4'($urandom);
            commit_in        = ($urandom_range(0, 2) == 0);
            commit_ticket_in = (ncom < q.size()) ? q[ncom].t : 4'($urandom);
            flush_in         = ($urandom_range(0, 19) == 0);
            drain_ready_in   = ($urandom_range(0, 2) != 0);
            ld_addr_in       = 32'h100 + 32'($urandom_range(0, 11));
            ld_byte_in       = 1'($urandom_range(0, 1));
            step();
        end

        idle(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
